// File: rtl/adder_operand_sequencer.sv
// -----------------------------------------------------------------------------
// adder_operand_sequencer
//
// Upstream stage of the 4-bit signed-adder display path. It takes two operands
// from the slide switches, one per debounced pushbutton press. It then computes
// their 4-bit two's-complement sum and the signed overflow of that sum, and
// holds the results registered for the seven-segment driver.
//
// Ports:
//   clk       in   1  system clock (50 MHz)
//   rst_n     in   1  synchronous active-low reset
//   sw        in   4  operand switches, asynchronous, two's-complement
//   key_n     in   1  pushbutton, active-low, asynchronous, bouncy
//   input1    out  4  captured operand A
//   input2    out  4  captured operand B
//   sum       out  4  input1 + input2 modulo 16
//   overflow  out  1  signed overflow of that sum
//   valid     out  1  high while sum/overflow match input1/input2 (S_SHOW)
//   state     out  2  FSM state: 00 S_A, 01 S_B, 10 S_CALC, 11 S_SHOW
// -----------------------------------------------------------------------------
module adder_operand_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       key_n,
  output logic [3:0] input1,
  output logic [3:0] input2,
  output logic [3:0] sum,
  output logic       overflow,
  output logic       valid,
  output logic [1:0] state
);

  localparam logic [1:0] S_A    = 2'b00;
  localparam logic [1:0] S_B    = 2'b01;
  localparam logic [1:0] S_CALC = 2'b10;
  localparam logic [1:0] S_SHOW = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchronizers
  logic             key_meta_q, key_s_q;
  logic [3:0]       sw_meta_q, sw_s_q;

  // Debounce and edge detect
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_db_q, key_db_d;
  logic             key_db_prev_q;
  logic             press;

  // FSM and datapath
  logic [1:0]       state_q, state_d;
  logic [3:0]       input1_q, input1_d;
  logic [3:0]       input2_q, input2_d;
  logic [3:0]       sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic [3:0]       sum_calc;

  // Debounced falling edge of the active-low key, i.e. the moment of a press.
  assign press    = key_db_prev_q & ~key_db_q;
  assign sum_calc = input1_q + input2_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // an incomplete assignment in always_comb would infer a latch.
    cnt_d    = '0;
    key_db_d = key_db_q;

    if (key_s_q != key_db_q) begin
      if (cnt_q == CNT_LAST) begin
        // The level has held for DEBOUNCE_CYCLES cycles: accept it and restart.
        key_db_d = key_s_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    state_d  = state_q;
    input1_d = input1_q;
    input2_d = input2_q;
    sum_d    = sum_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;

    case (state_q)
      S_A: begin
        if (press) begin
          input1_d = sw_s_q;
          state_d  = S_B;
        end
      end
      S_B: begin
        if (press) begin
          input2_d = sw_s_q;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        // A press cannot arrive here: presses are DEBOUNCE_CYCLES apart.
        sum_d   = sum_calc;
        // Signed overflow: the operands have the same sign and the result does not.
        ovf_d   = (input1_q[3] == input2_q[3]) && (sum_calc[3] != input1_q[3]);
        valid_d = 1'b1;
        state_d = S_SHOW;
      end
      default: begin // S_SHOW
        if (press) begin
          // Start a new calculation: the press supplies operand A directly.
          input1_d = sw_s_q;
          input2_d = '0;
          sum_d    = '0;
          ovf_d    = 1'b0;
          valid_d  = 1'b0;
          state_d  = S_B;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the key synchronizer resets to 1 (released) but the debounced
      // level resets to 0 (pressed). A key held through reset therefore never
      // produces a falling edge.
      key_meta_q    <= 1'b1;
      key_s_q       <= 1'b1;
      sw_meta_q     <= '0;
      sw_s_q        <= '0;
      cnt_q         <= '0;
      key_db_q      <= 1'b0;
      key_db_prev_q <= 1'b0;
      state_q       <= S_A;
      input1_q      <= '0;
      input2_q      <= '0;
      sum_q         <= '0;
      ovf_q         <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values. This is what gives the synchronizer chain its two-stage delay.
      key_meta_q    <= key_n;
      key_s_q       <= key_meta_q;
      sw_meta_q     <= sw;
      sw_s_q        <= sw_meta_q;
      cnt_q         <= cnt_d;
      key_db_q      <= key_db_d;
      key_db_prev_q <= key_db_q;
      state_q       <= state_d;
      input1_q      <= input1_d;
      input2_q      <= input2_d;
      sum_q         <= sum_d;
      ovf_q         <= ovf_d;
      valid_q       <= valid_d;
    end
  end

  assign input1   = input1_q;
  assign input2   = input2_q;
  assign sum      = sum_q;
  assign overflow = ovf_q;
  assign valid    = valid_q;
  assign state    = state_q;

endmodule
